qoi_buffer_ctrl: RTL
====================

// Module: qoi_buffer_ctrl
// PURPOSE
//   Sequences ownership of the two-bank QOI buffer memory between the 6502 (port A) and the QOI
//   engine (port B) by driving the memory unit's sel input.
//   The CPU programs a byte count and writes START; the block hands the banks to the engine,
//   pulses eng_start, waits for eng_done or a timeout, returns the banks and raises status/IRQ.
//   Sits between the CPU bus decode, the memory unit and the QOI engine core.
// PARAMETERS
//   ADDR_W     8      buffer address width; LEN register spans 1..2**ADDR_W bytes
//   TIMEOUT    4096   max cycles in RUN before forced abort; 0 disables the timeout
//   SETTLE     1      idle cycles after each sel change before the new owner may proceed
// PORTS
//   clk           in   1       clock
//   rst           in   1       reset, synchronous, active-high
//   reg_cs        in   1       CPU register select
//   reg_we        in   1       1=write, 0=read (qualified by reg_cs)
//   reg_addr      in   2       0=CTRL 1=STATUS 2=LEN 3=LEN_HI (bit0 = LEN[ADDR_W] when count=2**ADDR_W)
//   reg_data_i    in   8       CPU write data
//   reg_data_o    out  8       CPU read data, combinational from reg_addr
//   sel           out  1       0=CPU owns banks, 1=engine owns banks (to memory unit sel)
//   eng_start     out  1       single-cycle start pulse to QOI engine
//   eng_len       out  ADDR_W+1 byte count presented to engine, stable while busy
//   eng_done      in   1       engine completion pulse/level, sampled only in RUN
//   eng_abort     out  1       single-cycle abort pulse to engine
//   irq           out  1       level interrupt = done & irq_en
// BEHAVIOUR
//   Reset: state=IDLE, sel=0, eng_start=0, eng_abort=0, irq=0, LEN=0, irq_en=0, STATUS=0.
//   CTRL write: bit0 START, bit1 irq_en (sticky), bit2 ABORT; START/ABORT self-clear (read as 0).
//   STATUS read: bit0 busy, bit1 done, bit2 timeout, bit3 aborted, bit4 len_err; bits 7:5 = 0.
//   STATUS write: writing 1 to bit1..bit4 clears that bit (W1C); clearing done drops irq next cycle.
//   LEN/LEN_HI writable only in IDLE; writes while busy ignored. reg_data_o for LEN returns LEN.
//   FSM:
//     IDLE   : sel=0. START with LEN==0 or LEN>2**ADDR_W -> set len_err, stay IDLE.
//              Valid START -> clear done/timeout/aborted, latch eng_len, go HANDOFF.
//              START while done=1 is allowed (done cleared on accept).
//     HANDOFF: sel=1; wait SETTLE cycles; then go RUN, eng_start=1 for exactly the first RUN cycle.
//     RUN    : sel=1, busy=1; timeout counter increments each cycle.
//              eng_done=1 -> DRAIN (done path).
//              ABORT write or counter==TIMEOUT-1 -> eng_abort pulse, set aborted/timeout, DRAIN.
//              Same-cycle eng_done and ABORT/timeout: eng_done wins, no abort pulse.
//     DRAIN  : sel=0; wait SETTLE cycles; then set done=1 -> IDLE.
//   busy=1 in HANDOFF, RUN, DRAIN. START while busy ignored (no error bit).
//   eng_done outside RUN ignored. Engine latency unbounded except by TIMEOUT.
//   Latency START write -> eng_start = SETTLE+1 cycles; eng_done -> done = SETTLE+1 cycles.
//   sel never toggles more than once per SETTLE+1 cycles; eng_start never asserts with sel=0.
//   rst mid-operation: immediate return to reset values, sel=0 next edge; no abort pulse issued.
//   Timeout counter width clog2(TIMEOUT+1); cleared on HANDOFF entry; saturates, never wraps.
// TESTING
//   Normal: LEN=200, START -> sel=1 @+1, eng_start @+2; eng_done @+50 -> sel=0 @+1, done=1 @+2.
//   IRQ: irq_en=1, run to done -> irq=1; W1C STATUS bit1 -> irq=0 next cycle; START accepted again.
//   Timeout: TIMEOUT=16, never assert eng_done -> eng_abort pulse 16 cycles into RUN, STATUS=0x06.
//   Abort race: ABORT write same cycle as eng_done -> no eng_abort, STATUS=0x02, aborted=0.
//   Errors: START with LEN=0 -> len_err=1, sel stays 0; START/LEN write while busy -> ignored.
//   Reset in RUN: assert rst -> sel=0, busy=0, irq=0, LEN=0 next cycle; stray eng_done ignored.

Source files
------------

// File: rtl/qoi_buffer_ctrl_if.sv
// CPU register port plus memory-select and engine handshake of the QOI buffer controller.
// The controller takes the slave view; the bus decode / engine side takes the master view.
interface qoi_buffer_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              reg_cs;
    logic              reg_we;
    logic [1:0]        reg_addr;
    logic [7:0]        reg_data_i;
    logic [7:0]        reg_data_o;
    logic              sel;
    logic              eng_start;
    logic [ADDR_W:0]   eng_len;
    logic              eng_done;
    logic              eng_abort;
    logic              irq;

    modport slave (
        input  reg_cs,
        input  reg_we,
        input  reg_addr,
        input  reg_data_i,
        input  eng_done,
        output reg_data_o,
        output sel,
        output eng_start,
        output eng_len,
        output eng_abort,
        output irq
    );

    modport master (
        output reg_cs,
        output reg_we,
        output reg_addr,
        output reg_data_i,
        output eng_done,
        input  reg_data_o,
        input  sel,
        input  eng_start,
        input  eng_len,
        input  eng_abort,
        input  irq
    );
endinterface

// File: rtl/qoi_buffer_ctrl.sv
// Hands the two-bank QOI buffer between the 6502 and the QOI engine: the CPU programs LEN and
// writes START, the banks go to the engine for one job, then come back with status and IRQ.
module qoi_buffer_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 4096,
    parameter int SETTLE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    qoi_buffer_ctrl_if.slave bus
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [ADDR_W:0]  LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [SET_W-1:0] SET_LAST = (SETTLE > 1) ? SET_W'(SETTLE - 1) : '0;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_LEN    = 2'd2;
    localparam logic [1:0] A_LEN_HI = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HANDOFF,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t           state_q,     state_d;
    logic [ADDR_W:0]  len_q,       len_d;
    logic [ADDR_W:0]  eng_len_q,   eng_len_d;
    logic             irq_en_q,    irq_en_d;
    logic             done_q,      done_d;
    logic             timeout_q,   timeout_d;
    logic             aborted_q,   aborted_d;
    logic             len_err_q,   len_err_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [SET_W-1:0] settle_q,    settle_d;
    logic             eng_start_q, eng_start_d;
    logic             eng_abort_q, eng_abort_d;

    logic wr_ctrl;
    logic wr_status;
    logic wr_len;
    logic wr_len_hi;
    logic start_req;
    logic abort_req;
    logic len_ok;
    logic settle_done;
    logic timeout_hit;
    logic busy;

    assign wr_ctrl     = bus.reg_cs && bus.reg_we && (bus.reg_addr == A_CTRL);
    assign wr_status   = bus.reg_cs && bus.reg_we && (bus.reg_addr == A_STATUS);
    assign wr_len      = bus.reg_cs && bus.reg_we && (bus.reg_addr == A_LEN);
    assign wr_len_hi   = bus.reg_cs && bus.reg_we && (bus.reg_addr == A_LEN_HI);
    assign start_req   = wr_ctrl && bus.reg_data_i[0];
    assign abort_req   = wr_ctrl && bus.reg_data_i[2];
    assign len_ok      = (len_q != '0) && (len_q <= LEN_MAX);
    assign settle_done = (settle_q == SET_LAST);
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);
    assign busy        = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            eng_len_q   <= '0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            aborted_q   <= 1'b0;
            len_err_q   <= 1'b0;
            cnt_q       <= '0;
            settle_q    <= '0;
            eng_start_q <= 1'b0;
            eng_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            eng_len_q   <= eng_len_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            aborted_q   <= aborted_d;
            len_err_q   <= len_err_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            eng_start_q <= eng_start_d;
            eng_abort_q <= eng_abort_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        eng_len_d   = eng_len_q;
        irq_en_d    = irq_en_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        aborted_d   = aborted_q;
        len_err_d   = len_err_q;
        cnt_d       = cnt_q;
        settle_d    = settle_q;
        eng_start_d = 1'b0;
        eng_abort_d = 1'b0;

        if (wr_ctrl) begin
            irq_en_d = bus.reg_data_i[1];
        end

        // Clears come first so a flag being set by the FSM in the same cycle is not lost.
        if (wr_status) begin
            done_d    = done_q    & ~bus.reg_data_i[1];
            timeout_d = timeout_q & ~bus.reg_data_i[2];
            aborted_d = aborted_q & ~bus.reg_data_i[3];
            len_err_d = len_err_q & ~bus.reg_data_i[4];
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_len) begin
                    len_d[ADDR_W-1:0] = ADDR_W'(bus.reg_data_i);
                end
                if (wr_len_hi) begin
                    len_d[ADDR_W] = bus.reg_data_i[0];
                end
                if (start_req) begin
                    if (len_ok) begin
                        done_d    = 1'b0;
                        timeout_d = 1'b0;
                        aborted_d = 1'b0;
                        eng_len_d = len_q;
                        cnt_d     = '0;
                        settle_d  = '0;
                        state_d   = ST_HANDOFF;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end

            ST_HANDOFF: begin
                if (settle_done) begin
                    eng_start_d = 1'b1;
                    state_d     = ST_RUN;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A completing engine beats a concurrent abort or timeout.
                if (bus.eng_done) begin
                    settle_d = '0;
                    state_d  = ST_DRAIN;
                end else if (abort_req || timeout_hit) begin
                    eng_abort_d = 1'b1;
                    aborted_d   = aborted_q | abort_req;
                    timeout_d   = timeout_q | timeout_hit;
                    settle_d    = '0;
                    state_d     = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (settle_done) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.reg_data_o = 8'h00;
        case (bus.reg_addr)
            A_CTRL:   bus.reg_data_o = {6'b0, irq_en_q, 1'b0};
            A_STATUS: bus.reg_data_o = {3'b0, len_err_q, aborted_q, timeout_q, done_q, busy};
            A_LEN:    bus.reg_data_o = 8'(len_q[ADDR_W-1:0]);
            A_LEN_HI: bus.reg_data_o = {7'b0, len_q[ADDR_W]};
            default:  bus.reg_data_o = 8'h00;
        endcase
    end

    assign bus.sel       = (state_q == ST_HANDOFF) || (state_q == ST_RUN);
    assign bus.eng_start = eng_start_q;
    assign bus.eng_abort = eng_abort_q;
    assign bus.eng_len   = eng_len_q;
    assign bus.irq       = done_q & irq_en_q;

    // The engine must never be started without holding the banks.
    a_start_owns_banks: assert property (@(posedge clk) disable iff (rst)
        bus.eng_start |-> bus.sel);
    a_abort_single: assert property (@(posedge clk) disable iff (rst)
        bus.eng_abort |=> !bus.eng_abort);

endmodule
